// File: rtl/text_console_writer_pkg.sv
// ============================================================================
// Module      : text_console_writer_pkg
// Description : Shared geometry defaults, control codes and FSM encoding for
//               the text console writer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package text_console_writer_pkg;

    localparam int c_DEFAULT_COLS = 80;
    localparam int c_DEFAULT_ROWS = 30;

    localparam logic [7:0] c_CHAR_LF    = 8'h0A;
    localparam logic [7:0] c_CHAR_CR    = 8'h0D;
    localparam logic [7:0] c_CHAR_BS    = 8'h08;
    localparam logic [7:0] c_CHAR_SPACE = 8'h20;
    localparam logic [7:0] c_CHAR_TILDE = 8'h7E;

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_PUT     = 3'd1;
    localparam logic [2:0] c_ST_SCROLL  = 3'd2;
    localparam logic [2:0] c_ST_CLR_ROW = 3'd3;
    localparam logic [2:0] c_ST_CLR_ALL = 3'd4;

endpackage

`default_nettype wire

// File: rtl/text_console_writer_cursor.sv
// ============================================================================
// Module      : console_cursor
// Description : Column/row cursor counters with advance, newline, carriage
//               return, backspace and home; flags moves that need a scroll.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module console_cursor
    import text_console_writer_pkg::*;
#(
    parameter int COLS = c_DEFAULT_COLS,
    parameter int ROWS = c_DEFAULT_ROWS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_advance,
    input  logic       i_newline,
    input  logic       i_carriage,
    input  logic       i_backspace,
    input  logic       i_home,
    output logic [6:0] o_col,
    output logic [4:0] o_row,
    output logic       o_scroll
);

    localparam logic [6:0] c_LAST_COL = 7'(COLS - 1);
    localparam logic [4:0] c_LAST_ROW = 5'(ROWS - 1);

    logic [6:0] r_col;
    logic [4:0] r_row;
    logic       w_last_col;
    logic       w_last_row;

    assign w_last_col = (r_col == c_LAST_COL);
    assign w_last_row = (r_row == c_LAST_ROW);

    // Row saturates on the last line; the caller scrolls the screen instead.
    assign o_scroll = w_last_row && (i_newline || (i_advance && w_last_col));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_home) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_newline) begin
            r_col <= '0;
            if (!w_last_row) r_row <= r_row + 5'd1;
        end else if (i_advance) begin
            if (w_last_col) begin
                r_col <= '0;
                if (!w_last_row) r_row <= r_row + 5'd1;
            end else begin
                r_col <= r_col + 7'd1;
            end
        end else if (i_carriage) begin
            r_col <= '0;
        end else if (i_backspace && (r_col != 7'd0)) begin
            r_col <= r_col - 7'd1;
        end
    end

    assign o_col = r_col;
    assign o_row = r_row;

endmodule

`default_nettype wire

// File: rtl/text_console_writer.sv
// ============================================================================
// Module      : text_console_writer
// Description : Writes a character stream into a text-mode VRAM with cursor
//               handling, scrolling and full-screen clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module text_console_writer
    import text_console_writer_pkg::*;
#(
    parameter int COLS = c_DEFAULT_COLS,
    parameter int ROWS = c_DEFAULT_ROWS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        char_valid,
    input  logic [7:0]  char_data,
    output logic        char_ready,
    input  logic        clear_req,
    output logic        vram_we,
    output logic [18:0] vram_waddr,
    output logic [11:0] vram_wdata,
    output logic [18:0] vram_raddr,
    input  logic [11:0] vram_rdata,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy
);

    localparam logic [18:0] c_COLS_ADDR     = 19'(COLS);
    localparam logic [18:0] c_LAST_ADDR     = 19'(ROWS * COLS - 1);
    localparam logic [18:0] c_LAST_ROW_BASE = 19'((ROWS - 1) * COLS);

    logic [2:0]  r_state;
    logic [2:0]  w_state_nxt;
    logic [7:0]  r_char;
    logic        r_put_adv;
    logic [18:0] r_raddr;
    logic [18:0] r_waddr;
    logic        r_rd_more;
    logic        r_pend;

    logic        w_accept;
    logic        w_printable;
    logic        w_is_lf;
    logic        w_is_cr;
    logic        w_is_bs;
    logic        w_col_zero;
    logic        w_adv;
    logic        w_nl;
    logic        w_cr;
    logic        w_bs;
    logic        w_home;
    logic        w_scroll;
    logic        w_fill_done;
    logic        w_copy_done;
    logic [18:0] w_cur_addr;

    assign char_ready  = (r_state == c_ST_IDLE) && !clear_req;
    assign w_accept    = char_valid && char_ready;
    assign w_printable = (char_data >= c_CHAR_SPACE) && (char_data <= c_CHAR_TILDE);
    assign w_is_lf     = (char_data == c_CHAR_LF);
    assign w_is_cr     = (char_data == c_CHAR_CR);
    assign w_is_bs     = (char_data == c_CHAR_BS);
    assign w_col_zero  = (cursor_col == 7'd0);
    assign w_fill_done = (r_waddr == c_LAST_ADDR);
    assign w_copy_done = r_pend && !r_rd_more;
    assign w_cur_addr  = 19'(cursor_row) * c_COLS_ADDR + 19'(cursor_col);

    assign w_adv  = (r_state == c_ST_PUT) && r_put_adv;
    assign w_nl   = w_accept && w_is_lf;
    assign w_cr   = (w_accept && w_is_cr) || ((r_state == c_ST_CLR_ROW) && w_fill_done);
    assign w_bs   = w_accept && w_is_bs && !w_col_zero;
    assign w_home = (r_state == c_ST_CLR_ALL) && w_fill_done;

    console_cursor #(
        .COLS (COLS),
        .ROWS (ROWS)
    ) u_cursor (
        .clk         (clk),
        .rst         (rst),
        .i_advance   (w_adv),
        .i_newline   (w_nl),
        .i_carriage  (w_cr),
        .i_backspace (w_bs),
        .i_home      (w_home),
        .o_col       (cursor_col),
        .o_row       (cursor_row),
        .o_scroll    (w_scroll)
    );

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        vram_we     = 1'b0;
        vram_waddr  = r_waddr;
        vram_wdata  = {4'h0, c_CHAR_SPACE};
        case (r_state)
            c_ST_IDLE: begin
                if (clear_req) begin
                    w_state_nxt = c_ST_CLR_ALL;
                end else if (char_valid) begin
                    if (w_printable || (w_is_bs && !w_col_zero)) w_state_nxt = c_ST_PUT;
                    else if (w_is_lf && w_scroll)                w_state_nxt = c_ST_SCROLL;
                end
            end
            c_ST_PUT: begin
                vram_we     = 1'b1;
                vram_waddr  = w_cur_addr;
                vram_wdata  = {4'h0, r_char};
                w_state_nxt = w_scroll ? c_ST_SCROLL : c_ST_IDLE;
            end
            c_ST_SCROLL: begin
                // Write lags the read by one cycle to match VRAM read latency.
                vram_we    = r_pend;
                vram_wdata = vram_rdata;
                if (w_copy_done) w_state_nxt = c_ST_CLR_ROW;
            end
            c_ST_CLR_ROW, c_ST_CLR_ALL: begin
                vram_we = 1'b1;
                if (w_fill_done) w_state_nxt = c_ST_IDLE;
            end
            default: w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_char    <= '0;
            r_put_adv <= 1'b0;
            r_raddr   <= '0;
            r_waddr   <= '0;
            r_rd_more <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_char    <= w_is_bs ? c_CHAR_SPACE : char_data;
                r_put_adv <= !w_is_bs;
            end
            if ((r_state == c_ST_IDLE) && clear_req) r_waddr <= '0;
            if ((w_state_nxt == c_ST_SCROLL) && (r_state != c_ST_SCROLL)) begin
                r_raddr   <= c_COLS_ADDR;
                r_rd_more <= 1'b1;
                r_pend    <= 1'b0;
            end
            if (r_state == c_ST_SCROLL) begin
                if (w_copy_done) begin
                    r_waddr <= c_LAST_ROW_BASE;
                    r_pend  <= 1'b0;
                end else begin
                    r_pend <= r_rd_more;
                    if (r_rd_more) begin
                        r_waddr <= r_raddr - c_COLS_ADDR;
                        if (r_raddr == c_LAST_ADDR) r_rd_more <= 1'b0;
                        else                        r_raddr   <= r_raddr + 19'd1;
                    end
                end
            end
            if (((r_state == c_ST_CLR_ROW) || (r_state == c_ST_CLR_ALL)) && !w_fill_done)
                r_waddr <= r_waddr + 19'd1;
        end
    end

    assign vram_raddr = r_raddr;
    assign busy       = (r_state != c_ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_text_console_writer.sv
// ============================================================================
// Module      : tb_text_console_writer
// Description : Directed self-checking bench for text_console_writer with a
//               behavioural one-cycle-latency VRAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_text_console_writer;

    localparam int c_CELLS = 2400;

    logic        clk = 1'b0;
    logic        rst;
    logic        char_valid;
    logic [7:0]  char_data;
    logic        char_ready;
    logic        clear_req;
    logic        vram_we;
    logic [18:0] vram_waddr;
    logic [11:0] vram_wdata;
    logic [18:0] vram_raddr;
    logic [11:0] vram_rdata;
    logic [6:0]  cursor_col;
    logic [4:0]  cursor_row;
    logic        busy;

    logic [11:0] mem  [0:c_CELLS-1];
    logic [11:0] snap [0:c_CELLS-1];
    int          checks   = 0;
    int          failures = 0;
    int          oor      = 0;

    text_console_writer dut (
        .clk        (clk),
        .rst        (rst),
        .char_valid (char_valid),
        .char_data  (char_data),
        .char_ready (char_ready),
        .clear_req  (clear_req),
        .vram_we    (vram_we),
        .vram_waddr (vram_waddr),
        .vram_wdata (vram_wdata),
        .vram_raddr (vram_raddr),
        .vram_rdata (vram_rdata),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (vram_we) begin
            if (vram_waddr < 19'(c_CELLS)) mem[vram_waddr] <= vram_wdata;
            else                           oor <= oor + 1;
        end
        vram_rdata <= (vram_raddr < 19'(c_CELLS)) ? mem[vram_raddr] : 12'h000;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        char_valid = 1'b1;
        char_data  = c;
        tick();
        char_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic send_n(input logic [7:0] c, input int count);
        for (int i = 0; i < count; i++) begin
            send(c);
            wait_idle(10);
        end
    endtask

    initial begin
        int          n;
        int          cyc;
        int          bad;
        int          clr_n;
        logic [18:0] first_addr;
        logic [11:0] first_data;

        for (int i = 0; i < c_CELLS; i++) mem[i] = 12'(i * 37 + 5);
        rst = 1'b1; char_valid = 1'b0; char_data = 8'h00; clear_req = 1'b0;
        tick(); tick();
        chk("rst_we", 32'(vram_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(char_ready), 32'd1);
        chk("rst_cursor", {cursor_row, cursor_col}, {5'd0, 7'd0});
        chk("rst_raddr", 32'(vram_raddr), 32'd0);
        rst = 1'b0;
        tick();

        // Printable character: write lands one cycle after acceptance.
        send(8'h41);
        chk("A_we", 32'(vram_we), 32'd1);
        chk("A_waddr", 32'(vram_waddr), 32'd0);
        chk("A_wdata", 32'(vram_wdata), 32'h041);
        tick();
        chk("A_cursor", {cursor_row, cursor_col}, {5'd0, 7'd1});

        send(8'h01);
        chk("other_we", 32'(vram_we), 32'd0);
        chk("other_cursor", {cursor_row, cursor_col}, {5'd0, 7'd1});

        send(8'h0D);
        chk("cr_we", 32'(vram_we), 32'd0);
        chk("cr_cursor", {cursor_row, cursor_col}, {5'd0, 7'd0});

        send_n(8'h0A, 3);
        send(8'h08);
        chk("bs0_we", 32'(vram_we), 32'd0);
        chk("bs0_cursor", {cursor_row, cursor_col}, {5'd3, 7'd0});

        send_n(8'h62, 4);
        chk("pre_bs_cursor", {cursor_row, cursor_col}, {5'd3, 7'd4});
        send(8'h08);
        chk("bs_we", 32'(vram_we), 32'd1);
        chk("bs_waddr", 32'(vram_waddr), 32'd243);
        chk("bs_wdata", 32'(vram_wdata), 32'h020);
        tick();
        chk("bs_cursor", {cursor_row, cursor_col}, {5'd3, 7'd3});

        // Column wrap at the end of a non-final row.
        send_n(8'h0D, 1);
        send_n(8'h0A, 2);
        send_n(8'h63, 79);
        chk("wrap_pre", {cursor_row, cursor_col}, {5'd5, 7'd79});
        send(8'h42);
        chk("wrap_we", 32'(vram_we), 32'd1);
        chk("wrap_waddr", 32'(vram_waddr), 32'd479);
        chk("wrap_wdata", 32'(vram_wdata), 32'h042);
        tick();
        chk("wrap_cursor", {cursor_row, cursor_col}, {5'd6, 7'd0});

        // clear_req while not idle has no effect.
        send(8'h64);
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        chk("clr_ignored_busy", 32'(busy), 32'd0);
        chk("clr_ignored_cursor", {cursor_row, cursor_col}, {5'd6, 7'd1});

        // Newline on the last row scrolls and blanks the final line.
        send_n(8'h0D, 1);
        send_n(8'h0A, 23);
        send_n(8'h65, 10);
        chk("scroll_pre", {cursor_row, cursor_col}, {5'd29, 7'd10});
        for (int i = 0; i < c_CELLS; i++) snap[i] = mem[i];
        send(8'h0A);
        chk("scroll_busy", 32'(busy), 32'd1);
        chk("scroll_raddr0", 32'(vram_raddr), 32'd80);
        chk("scroll_cursor_now", {cursor_row, cursor_col}, {5'd29, 7'd0});
        n = 0; cyc = 0; bad = 0; clr_n = 0;
        first_addr = '1; first_data = '1;
        while (busy && cyc < 6000) begin
            if (vram_we) begin
                if (n == 0) begin
                    first_addr = vram_waddr;
                    first_data = vram_wdata;
                end
                if (n < 2320) begin
                    if (vram_waddr != 19'(n) || vram_wdata != snap[n + 80]) bad++;
                end else begin
                    if (vram_waddr != 19'(n) || vram_wdata != 12'h020) bad++;
                    clr_n++;
                end
                n++;
            end
            tick();
            cyc++;
        end
        chk("scroll_done", 32'(busy), 32'd0);
        chk("scroll_first_waddr", 32'(first_addr), 32'd0);
        chk("scroll_first_wdata", 32'(first_data), 32'(snap[80]));
        chk("scroll_copy_count", 32'(n - clr_n), 32'd2320);
        chk("scroll_clr_count", 32'(clr_n), 32'd80);
        chk("scroll_bad_writes", 32'(bad), 32'd0);
        chk("scroll_cursor", {cursor_row, cursor_col}, {5'd29, 7'd0});

        // Reset in the middle of a scroll.
        send(8'h0A);
        for (int i = 0; i < 99; i++) tick();
        chk("midscroll_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        chk("mrst_we", 32'(vram_we), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_ready", 32'(char_ready), 32'd1);
        chk("mrst_cursor", {cursor_row, cursor_col}, {5'd0, 7'd0});
        chk("mrst_raddr", 32'(vram_raddr), 32'd0);
        rst = 1'b0;
        tick();

        // clear_req beats a simultaneous character.
        send_n(8'h51, 1);
        chk("pre_clr_cursor", {cursor_row, cursor_col}, {5'd0, 7'd1});
        clear_req = 1'b1; char_valid = 1'b1; char_data = 8'h5A;
        #1;
        chk("clr_ready", 32'(char_ready), 32'd0);
        tick();
        clear_req = 1'b0; char_valid = 1'b0;
        n = 0; cyc = 0; bad = 0;
        while (busy && cyc < 6000) begin
            if (vram_we) begin
                if (vram_waddr != 19'(n) || vram_wdata != 12'h020) bad++;
                n++;
            end
            tick();
            cyc++;
        end
        chk("clr_done", 32'(busy), 32'd0);
        chk("clr_count", 32'(n), 32'd2400);
        chk("clr_bad_writes", 32'(bad), 32'd0);
        chk("clr_cursor", {cursor_row, cursor_col}, {5'd0, 7'd0});
        chk("addr_range", 32'(oor), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/text_console_writer.md
TEXT_CONSOLE_WRITER -- requirements
Module: text_console_writer

Interface
REQ-001 Parameter COLS, default 80, text columns per row.
REQ-002 Parameter ROWS, default 30, text rows per screen (480/16).
REQ-003 clk  input  1  system clock; one clock, all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 char_valid  input  1  character offered.
REQ-006 char_data  input  8  character code.
REQ-007 char_ready  output  1  character accepted when char_valid&char_ready.
REQ-008 clear_req  input  1  single-cycle request to blank the screen.
REQ-009 vram_we  output  1  VRAM write strobe.
REQ-010 vram_waddr  output  19  write address = row*COLS+col.
REQ-011 vram_wdata  output  12  write data: {4'h0, char code}.
REQ-012 vram_raddr  output  19  read address (scroll only).
REQ-013 vram_rdata  input  12  read data, valid exactly one cycle after vram_raddr.
REQ-014 cursor_col  output  7  current column, 0..COLS-1.
REQ-015 cursor_row  output  5  current row, 0..ROWS-1.
REQ-016 busy  output  1  high in any state other than IDLE.

Function
REQ-017 The FSM SHALL have states IDLE, PUT, SCROLL, CLR_ROW, CLR_ALL.
REQ-018 char_ready SHALL be high only in IDLE with clear_req low; clear_req SHALL win over a simultaneous char_valid.
REQ-019 Accepted printable code (0x20..0x7E) SHALL be written in the next cycle (PUT): vram_we=1, addr=cursor position, then cursor advances.
REQ-020 Advance past col COLS-1 SHALL set col=0, row+1; from row ROWS-1 it SHALL enter SCROLL with row staying ROWS-1.
REQ-021 0x0A SHALL set col=0, row+1 (SCROLL if on last row), no write.
REQ-022 0x0D SHALL set col=0, no write.
REQ-023 0x08 at col>0 SHALL decrement col and write 0x20 at the new position; at col 0 it SHALL be a no-op.
REQ-024 Other codes SHALL be accepted and discarded, no write, cursor unchanged.
REQ-025 SCROLL SHALL copy addresses COLS..ROWS*COLS-1 to addr-COLS: read issued cycle k, write of that data at cycle k+1, one cell per cycle, (ROWS-1)*COLS writes total.
REQ-026 CLR_ROW SHALL write 0x020 to all COLS cells of row ROWS-1, one per cycle, then return to IDLE with col=0.
REQ-027 clear_req sampled in IDLE SHALL enter CLR_ALL: writes 0x020 to addresses 0..ROWS*COLS-1 ascending, then cursor=(0,0), IDLE.
REQ-028 clear_req outside IDLE SHALL be ignored.
REQ-029 vram_we SHALL be 0 in IDLE; no write SHALL exceed address ROWS*COLS-1.
REQ-030 Address arithmetic SHALL be unsigned 19-bit; no wrap of the copy counter beyond its terminal count.

Reset
REQ-031 rst SHALL force IDLE, cursor (0,0), vram_we=0, vram_raddr=0, busy=0, char_ready=1 at the next edge, including mid-SCROLL/CLR; VRAM content is not touched.

Structure
REQ-032 A shared package SHALL hold COLS/ROWS defaults, control codes (0x0A, 0x0D, 0x08, 0x20) and the state encoding.
REQ-033 One sub-module, console_cursor (col/row counters with advance/newline/backspace/scroll flag), SHALL be used; FSM and VRAM sequencing stay in the top.

Verification
REQ-034 After reset, send 'A'(0x41) -> one cycle later vram_we=1, waddr=0, wdata=0x041; cursor (1,0).
REQ-035 Cursor (79,5), send 0x42 -> write at 479; cursor (0,6).
REQ-036 Cursor (10,29), send 0x0A -> 2320 copy writes (first: raddr 80 then waddr 0 with that data), 80 writes of 0x020 at 2320..2399, cursor (0,29), busy low after.
REQ-037 Cursor (0,3), send 0x08 -> no write, cursor (0,3); cursor (4,3), 0x08 -> write 0x020 at 243, cursor (3,3).
REQ-038 clear_req and char_valid same cycle -> char not accepted, 2400 writes of 0x020 at 0..2399, cursor (0,0).
REQ-039 rst asserted 100 cycles into SCROLL -> next cycle vram_we=0, IDLE, cursor (0,0), char_ready=1.
